// File: rtl/sl_sequencer.sv
// sl_sequencer
//   Multicycle shift-left sequencer. Performs a shift-left by 0..2^AMTW-1
//   positions by iterating one external combinational shift-left-by-1 unit
//   (sl1) once per cycle. Two requesters share the unit under round-robin
//   arbitration with a req/gnt/done handshake.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   req0, a0, amt0    : requester 0 request, operand, shift amount
//   req1, a1, amt1    : requester 1 request, operand, shift amount
//   gnt               : one-hot grant, combinational, only ever set in IDLE
//   busy              : high while a shift is in progress or completing
//   done              : one-cycle pulse, y/done_id valid while high
//   done_id           : requester whose result is on y
//   y                 : result register, held until the next done
//   sl_in / sl_out    : operand to / result from the external sl1 unit
module sl_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [AMTW-1:0]  amt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [AMTW-1:0]  amt1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sl_in,
  input  logic [WIDTH-1:0] sl_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMTW-1:0]  cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             done_id_q, done_id_d;

  logic             sel;
  logic [WIDTH-1:0] a_sel;
  logic [AMTW-1:0]  amt_sel;
  logic [1:0]       gnt_raw;

  // Arbitration: a lone requester wins outright, a tie goes to rr_ptr.
  // Depends only on req* and rr_ptr, never on operands.
  always_comb begin
    sel = rr_ptr_q;
    if (req0 && !req1) sel = 1'b0;
    else if (req1 && !req0) sel = 1'b1;
    a_sel   = sel ? a1   : a0;
    amt_sel = sel ? amt1 : amt0;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through
    // the case leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    y_d       = y_q;
    done_id_d = done_id_q;
    gnt_raw   = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_raw[sel] = 1'b1;
          acc_d        = a_sel;
          cnt_d        = amt_sel;
          id_d         = sel;
          rr_ptr_d     = ~sel;
          if (amt_sel != '0) begin
            state_d = S_SHIFT;
          end else begin
            // Zero amount: the operand itself is the result.
            state_d   = S_DONE;
            y_d       = a_sel;
            done_id_d = sel;
          end
        end
      end
      S_SHIFT: begin
        acc_d = sl_out;
        cnt_d = cnt_q - AMTW'(1);
        if (cnt_q == AMTW'(1)) begin
          state_d   = S_DONE;
          y_d       = sl_out;
          done_id_d = id_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      rr_ptr_q  <= 1'b0;
      y_q       <= '0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      y_q       <= y_d;
      done_id_q <= done_id_d;
    end
  end

  // The grant is suppressed while reset is asserted: a requester holding its
  // request through reset must not see a grant that the flops cannot honour.
  assign gnt     = gnt_raw & {2{rst_n}};
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign done_id = done_id_q;
  assign y       = y_q;
  assign sl_in   = acc_q;

endmodule

// File: tb/tb_sl_sequencer.sv
// tb_sl_sequencer
//   Self-checking bench for sl_sequencer. Inputs change on the falling edge,
//   outputs are sampled 1 ns later. Expected results are pushed to a
//   scoreboard queue at grant time and popped when done pulses.
module tb_sl_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, a1;
  logic [3:0]  amt0, amt1;
  logic [1:0]  gnt;
  logic        busy, done, done_id;
  logic [15:0] y, sl_in, sl_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [15:0] y;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic        r0;
    logic [15:0] a0;
    logic [3:0]  amt0;
    logic        r1;
    logic [15:0] a1;
    logic [3:0]  amt1;
    logic [1:0]  exp_gnt;
    logic [15:0] exp_y;
  } vec_t;

  sl_sequencer #(.WIDTH(16), .AMTW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .a0      (a0),
    .amt0    (amt0),
    .req1    (req1),
    .a1      (a1),
    .amt1    (amt1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .y       (y),
    .sl_in   (sl_in),
    .sl_out  (sl_out)
  );

  // Model of the external sl1 unit.
  assign sl_out = sl_in << 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},     32'(gnt),     32'(2'b00));
    check({tag, "_busy"},    32'(busy),    32'(1'b0));
    check({tag, "_done"},    32'(done),    32'(1'b0));
    check({tag, "_done_id"}, 32'(done_id), 32'(1'b0));
    check({tag, "_y"},       32'(y),       32'(16'h0000));
    check({tag, "_sl_in"},   32'(sl_in),   32'(16'h0000));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Follows a transaction from the cycle after its grant until done. Requests
  // are dropped in cycle 1; busy must stay high until done, done must come
  // exactly at exp_lat, and the result must hold afterwards.
  task automatic wait_done(input string tag, input int exp_lat);
    bit          seen;
    exp_t        e;
    logic [15:0] held_y;
    seen   = 1'b0;
    held_y = '0;
    for (int c = 1; c <= exp_lat + 3 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      #1;
      check({tag, "_busy"}, 32'(busy), 32'(1'b1));
      check({tag, "_gnt_while_busy"}, 32'(gnt), 32'(2'b00));
      if (done) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(c), 32'(exp_lat));
        if (sb_q.size() == 0) begin
          fail_now({tag, "_unexpected_done"});
        end else begin
          e = sb_q.pop_front();
          check({tag, "_y"},       32'(y),       32'(e.y));
          check({tag, "_done_id"}, 32'(done_id), 32'(e.id));
        end
        held_y = y;
      end
    end
    if (!seen) begin
      fail_now({tag, "_timeout_waiting_done"});
    end else begin
      @(negedge clk);
      #1;
      check({tag, "_done_pulse_width"}, 32'(done), 32'(1'b0));
      check({tag, "_busy_after"},       32'(busy), 32'(1'b0));
      check({tag, "_y_hold"},           32'(y),    32'(held_y));
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t  e;
    string tag;
    int    lat;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    req0 = v.r0; a0 = v.a0; amt0 = v.amt0;
    req1 = v.r1; a1 = v.a1; amt1 = v.amt1;
    #1;
    check({tag, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
    check({tag, "_idle_busy"}, 32'(busy), 32'(1'b0));
    e.id = v.exp_gnt[1];
    e.y  = v.exp_y;
    sb_q.push_back(e);
    lat = (v.exp_gnt[1] ? int'(v.amt1) : int'(v.amt0)) + 1;
    wait_done(tag, lat);
  endtask

  initial begin
    vec_t vecs[7];
    int   n_grants, n_dones, last_grant;
    logic exp_next;
    exp_t e;

    // {r0, a0, amt0, r1, a1, amt1, exp_gnt, exp_y}
    vecs[0] = '{1'b1, 16'hffff, 4'd1,  1'b0, 16'h0000, 4'd0, 2'b01, 16'hfffe};
    vecs[1] = '{1'b0, 16'h0000, 4'd0,  1'b1, 16'habcd, 4'd4, 2'b10, 16'hbcd0};
    vecs[2] = '{1'b1, 16'h1234, 4'd0,  1'b0, 16'h0000, 4'd0, 2'b01, 16'h1234};
    vecs[3] = '{1'b1, 16'h0001, 4'd15, 1'b0, 16'h0000, 4'd0, 2'b01, 16'h8000};
    vecs[4] = '{1'b1, 16'habcd, 4'd15, 1'b0, 16'h0000, 4'd0, 2'b01, 16'h8000};
    // Ties: rr_ptr points at 1 after vec4 (last winner 0), then back at 0.
    vecs[5] = '{1'b1, 16'h5555, 4'd1,  1'b1, 16'h00f0, 4'd3, 2'b10, 16'h0780};
    vecs[6] = '{1'b1, 16'h8421, 4'd2,  1'b1, 16'hffff, 4'd7, 2'b01, 16'h1084};

    rst_n = 1'b0;
    req0 = 1'b0; a0 = '0; amt0 = '0;
    req1 = 1'b0; a1 = '0; amt1 = '0;
    #1;
    check_reset_outputs("init");
    apply_reset();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Arbitration: both requests held continuously, amount 2 each. Grants
    // must alternate starting with 0 and be spaced N+2 = 4 cycles apart.
    apply_reset();
    n_grants   = 0;
    n_dones    = 0;
    last_grant = 0;
    exp_next   = 1'b0;
    @(negedge clk);
    req0 = 1'b1; a0 = 16'h0003; amt0 = 4'd2;
    req1 = 1'b1; a1 = 16'h0005; amt1 = 4'd2;
    for (int cyc = 0; cyc < 40 && n_dones < 4; cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (busy) check("arb_gnt_while_busy", 32'(gnt), 32'(2'b00));
      if (gnt != 2'b00) begin
        check("arb_gnt", 32'(gnt), exp_next ? 32'(2'b10) : 32'(2'b01));
        if (n_grants > 0) check("arb_spacing", 32'(cyc - last_grant), 32'd4);
        e.id = exp_next;
        e.y  = exp_next ? (a1 << 2) : (a0 << 2);
        sb_q.push_back(e);
        exp_next   = ~exp_next;
        last_grant = cyc;
        n_grants++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          fail_now("arb_unexpected_done");
        end else begin
          e = sb_q.pop_front();
          check("arb_y",       32'(y),       32'(e.y));
          check("arb_done_id", 32'(done_id), 32'(e.id));
        end
        n_dones++;
      end
    end
    if (n_dones < 4) fail_now("arb_timeout_waiting_done");
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    sb_q.delete();

    // Reset mid-operation: amount 8, reset pulsed in cycle 3 between edges.
    @(negedge clk);
    #1;
    @(negedge clk);
    req0 = 1'b1; a0 = 16'h00ff; amt0 = 4'd8;
    #1;
    check("rst_mid_gnt", 32'(gnt), 32'(2'b01));
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      #1;
      check("rst_mid_busy", 32'(busy), 32'(1'b1));
      check("rst_mid_no_done", 32'(done), 32'(1'b0));
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #1;
    rst_n = 1'b1;
    #1;
    // req0 is still held, so a fresh grant appears in the first IDLE cycle.
    check("rst_regrant_gnt", 32'(gnt), 32'(2'b01));
    e.id = 1'b0;
    e.y  = 16'hff00;
    sb_q.push_back(e);
    wait_done("rst_regrant", 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
